sys_step_ctrl: RTL and testbench

Parametrised CPU clock-enable generator for the MIPS system. It replaces the fixed clock divisor with a run/halt/single-step/run-to-breakpoint controller. The block drives a one-cycle cpu_ce pulse that the datapath uses as its clock enable, with everything clocked from SYS_clk. It also drives CLK_led, a halted flag, a sticky breakpoint flag and a retired-enable counter for the board LEDs.

---
 rtl/sys_step_ctrl.sv | 128 ++++++++++++
 tb/tb_sys_step_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_step_ctrl.sv
// sys_step_ctrl: CPU clock-enable generator for the MIPS system.
// The CPU can be held in HALT, run free at SYS_clk/DIVISOR (RUN), advanced
// one cpu_ce per debounced button edge (STEP), or run until the PC matches a
// breakpoint (RUN_TO_BP). The block also drives CLK_led, a halted flag, a
// sticky breakpoint flag and a saturating count of issued enables.
//
// Interface note: there is no valid/ready handshake here. cpu_ce is a
// one-cycle strobe, and the datapath is expected to act on it in that same
// cycle. pc must stay stable between strobes.
module sys_step_ctrl #(
    parameter int unsigned DIVISOR = 1,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PC_W    = 8,
    parameter int unsigned CYC_W   = 32
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic [1:0]       mode_sel,
    input  logic             step_btn,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_ce,
    output logic             CLK_led,
    output logic             halted,
    output logic             bp_hit,
    output logic [CYC_W-1:0] cycle_cnt
);

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_RTB  = 2'b11;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIVISOR - 1);

    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic             clk_led_q, clk_led_d;
    logic             halted_q, halted_d;
    logic             bp_hit_q, bp_hit_d;
    logic [CYC_W-1:0] cycle_cnt_q, cycle_cnt_d;

    logic mode_change;
    logic run_mode;
    logic tick;
    logic step_edge;
    logic bp_match;

    // Next-state logic: divider, step edge detect, breakpoint and enable generation.
    always_comb begin
        mode_change = (mode_sel != mode_q);
        run_mode    = (mode_sel == MODE_RUN) || (mode_sel == MODE_RTB);
        // A mode change suppresses the tick so the new mode starts from a clean count.
        tick        = run_mode && !mode_change && (div_cnt_q == DIV_LAST);

        mode_d = mode_sel;
        if (!run_mode || mode_change || (div_cnt_q == DIV_LAST)) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + CNT_W'(1);
        end

        // The synchroniser and edge register run in every mode, so an edge seen
        // outside STEP is consumed there and never queued.
        sync1_d   = step_btn;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        step_edge = sync2_q & ~prev_q;

        bp_match = tick && (mode_sel == MODE_RTB) && bp_en && (pc == bp_addr);
        bp_hit_d = (mode_sel == MODE_RTB) && (bp_hit_q || bp_match);

        cpu_ce_d = 1'b0;
        case (mode_sel)
            MODE_RUN:  cpu_ce_d = tick;
            MODE_RTB:  cpu_ce_d = tick && !bp_hit_q && !bp_match;
            MODE_STEP: cpu_ce_d = step_edge;
            default:   cpu_ce_d = 1'b0;
        endcase

        clk_led_d = clk_led_q ^ cpu_ce_d;
        halted_d  = (mode_sel == MODE_HALT) || bp_hit_d;

        cycle_cnt_d = cycle_cnt_q;
        if (cpu_ce_d && (cycle_cnt_q != {CYC_W{1'b1}})) begin
            cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            mode_q      <= MODE_HALT;
            div_cnt_q   <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            cpu_ce_q    <= 1'b0;
            clk_led_q   <= 1'b0;
            halted_q    <= 1'b0;
            bp_hit_q    <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            mode_q      <= mode_d;
            div_cnt_q   <= div_cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            cpu_ce_q    <= cpu_ce_d;
            clk_led_q   <= clk_led_d;
            halted_q    <= halted_d;
            bp_hit_q    <= bp_hit_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cpu_ce    = cpu_ce_q;
    assign CLK_led   = clk_led_q;
    assign halted    = halted_q;
    assign bp_hit    = bp_hit_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_sys_step_ctrl.sv
// Bench for sys_step_ctrl: four instances with different DIVISOR/CYC_W share
// one stimulus stream; each scenario checks the instance it targets.
module tb_sys_step_ctrl;

    logic       SYS_clk;
    logic       SYS_reset;
    logic [1:0] mode_sel;
    logic       step_btn;
    logic       bp_en;
    logic [7:0] bp_addr;
    logic [7:0] pc;

    logic        ce4, led4, hlt4, bp4;
    logic [31:0] cnt4;
    logic        ce1, led1, hlt1, bp1;
    logic [31:0] cnt1;
    logic        ce2, led2, hlt2, bp2;
    logic [31:0] cnt2;
    logic        ces, leds, hlts, bps;
    logic [3:0]  cnts;

    int n_vec;
    int n_err;

    sys_step_ctrl #(.DIVISOR(4), .CNT_W(32), .PC_W(8), .CYC_W(32)) u_d4 (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .mode_sel(mode_sel), .step_btn(step_btn),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_ce(ce4), .CLK_led(led4),
        .halted(hlt4), .bp_hit(bp4), .cycle_cnt(cnt4));

    sys_step_ctrl #(.DIVISOR(1), .CNT_W(32), .PC_W(8), .CYC_W(32)) u_d1 (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .mode_sel(mode_sel), .step_btn(step_btn),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_ce(ce1), .CLK_led(led1),
        .halted(hlt1), .bp_hit(bp1), .cycle_cnt(cnt1));

    sys_step_ctrl #(.DIVISOR(2), .CNT_W(32), .PC_W(8), .CYC_W(32)) u_d2 (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .mode_sel(mode_sel), .step_btn(step_btn),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_ce(ce2), .CLK_led(led2),
        .halted(hlt2), .bp_hit(bp2), .cycle_cnt(cnt2));

    sys_step_ctrl #(.DIVISOR(1), .CNT_W(32), .PC_W(8), .CYC_W(4)) u_sat (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .mode_sel(mode_sel), .step_btn(step_btn),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_ce(ces), .CLK_led(leds),
        .halted(hlts), .bp_hit(bps), .cycle_cnt(cnts));

    // Clock: 10 time-unit period.
    initial begin
        SYS_clk = 1'b0;
        forever #5 SYS_clk = ~SYS_clk;
    end

    // Advance one rising edge; outputs are sampled and inputs changed 1 unit later.
    task automatic step_clk();
        @(posedge SYS_clk);
        #1;
    endtask

    // One reset edge with the current mode_sel, then release.
    task automatic do_reset();
        SYS_reset = 1'b1;
        step_clk();
        SYS_reset = 1'b0;
    endtask

    task automatic test_reset();
        mode_sel = 2'b01; step_btn = 1'b0; bp_en = 1'b0; bp_addr = 8'h00; pc = 8'h00;
        do_reset();
        n_vec++; if (ce4 !== 1'b0)   begin n_err++; $display("FAIL reset_ce got %b exp 0", ce4); end
        n_vec++; if (led4 !== 1'b0)  begin n_err++; $display("FAIL reset_led got %b exp 0", led4); end
        n_vec++; if (hlt4 !== 1'b0)  begin n_err++; $display("FAIL reset_halted got %b exp 0", hlt4); end
        n_vec++; if (bp4 !== 1'b0)   begin n_err++; $display("FAIL reset_bp got %b exp 0", bp4); end
        n_vec++; if (cnt4 !== 32'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", cnt4); end
        n_vec++; if (cnts !== 4'd0)  begin n_err++; $display("FAIL reset_cnt_sat got %0d exp 0", cnts); end
    endtask

    // DIVISOR=4: edge 0 after release is the mode change, pulses after edges 4,8,...,20.
    task automatic test_run_div4();
        mode_sel = 2'b01;
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            step_clk();
            n_vec++;
            if (ce4 !== ((k >= 4) && (k % 4 == 0))) begin
                n_err++; $display("FAIL run4_ce edge %0d got %b exp %b", k, ce4, ((k >= 4) && (k % 4 == 0)));
            end
        end
        n_vec++; if (cnt4 !== 32'd5) begin n_err++; $display("FAIL run4_cnt got %0d exp 5", cnt4); end
        n_vec++; if (led4 !== 1'b1)  begin n_err++; $display("FAIL run4_led got %b exp 1", led4); end
        n_vec++; if (hlt4 !== 1'b0)  begin n_err++; $display("FAIL run4_halted got %b exp 0", hlt4); end
    endtask

    // DIVISOR=1: ce on every edge from edge 1, then HALT stops it and raises halted.
    task automatic test_run_halt_div1();
        mode_sel = 2'b01;
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            step_clk();
            n_vec++;
            if (ce1 !== (k >= 1)) begin
                n_err++; $display("FAIL run1_ce edge %0d got %b exp %b", k, ce1, (k >= 1));
            end
        end
        n_vec++; if (cnt1 !== 32'd10) begin n_err++; $display("FAIL run1_cnt got %0d exp 10", cnt1); end
        mode_sel = 2'b00;
        step_clk();
        n_vec++; if (ce1 !== 1'b0)    begin n_err++; $display("FAIL halt_ce got %b exp 0", ce1); end
        n_vec++; if (hlt1 !== 1'b1)   begin n_err++; $display("FAIL halt_halted got %b exp 1", hlt1); end
        step_clk();
        n_vec++; if (ce1 !== 1'b0)    begin n_err++; $display("FAIL halt_ce2 got %b exp 0", ce1); end
        n_vec++; if (cnt1 !== 32'd10) begin n_err++; $display("FAIL halt_cnt got %0d exp 10", cnt1); end
    endtask

    // Three presses in STEP, each giving one pulse on the 3rd edge; a HALT press gives none.
    task automatic test_step();
        mode_sel = 2'b10; step_btn = 1'b0;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            step_btn = 1'b1;
            for (int i = 1; i <= 12; i++) begin
                if (i == 7) step_btn = 1'b0;
                step_clk();
                n_vec++;
                if (ce1 !== (i == 3)) begin
                    n_err++; $display("FAIL step_ce press %0d edge %0d got %b exp %b", p, i, ce1, (i == 3));
                end
            end
        end
        n_vec++; if (cnt1 !== 32'd3) begin n_err++; $display("FAIL step_cnt got %0d exp 3", cnt1); end
        n_vec++; if (led1 !== 1'b1)  begin n_err++; $display("FAIL step_led got %b exp 1", led1); end
        mode_sel = 2'b00;
        step_btn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            if (i == 7) step_btn = 1'b0;
            step_clk();
            n_vec++; if (ce1 !== 1'b0) begin n_err++; $display("FAIL halt_press_ce edge %0d got %b exp 0", i, ce1); end
        end
        mode_sel = 2'b10;
        for (int i = 1; i <= 4; i++) begin
            step_clk();
            n_vec++; if (ce1 !== 1'b0) begin n_err++; $display("FAIL step_noqueue_ce edge %0d got %b exp 0", i, ce1); end
        end
        n_vec++; if (cnt1 !== 32'd3) begin n_err++; $display("FAIL step_cnt_after got %0d exp 3", cnt1); end
    endtask

    // DIVISOR=2 run-to-breakpoint with pc += 4 per pulse; hit at edge 8, then step past.
    task automatic test_run_to_bp();
        int pulses;
        int hit_at;
        mode_sel = 2'b11; bp_en = 1'b1; bp_addr = 8'h0C; pc = 8'h00; step_btn = 1'b0;
        do_reset();
        pulses = 0; hit_at = -1;
        for (int k = 0; k < 20; k++) begin
            step_clk();
            if (ce2 === 1'b1) begin pulses++; pc = pc + 8'd4; end
            if ((bp2 === 1'b1) && (hit_at < 0)) hit_at = k;
        end
        n_vec++; if (pulses !== 3)   begin n_err++; $display("FAIL bp_pulses got %0d exp 3", pulses); end
        n_vec++; if (pc !== 8'h0C)   begin n_err++; $display("FAIL bp_pc got %h exp 0c", pc); end
        n_vec++; if (hit_at !== 8)   begin n_err++; $display("FAIL bp_hit_edge got %0d exp 8", hit_at); end
        n_vec++; if (bp2 !== 1'b1)   begin n_err++; $display("FAIL bp_hit got %b exp 1", bp2); end
        n_vec++; if (hlt2 !== 1'b1)  begin n_err++; $display("FAIL bp_halted got %b exp 1", hlt2); end
        n_vec++; if (cnt2 !== 32'd3) begin n_err++; $display("FAIL bp_cnt got %0d exp 3", cnt2); end
        mode_sel = 2'b10;
        step_clk();
        n_vec++; if (bp2 !== 1'b0)  begin n_err++; $display("FAIL bp_clear got %b exp 0", bp2); end
        n_vec++; if (hlt2 !== 1'b0) begin n_err++; $display("FAIL bp_halted_clear got %b exp 0", hlt2); end
        pulses = 0;
        step_btn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            if (i == 7) step_btn = 1'b0;
            step_clk();
            if (ce2 === 1'b1) begin pulses++; pc = pc + 8'd4; end
        end
        n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL bp_step_pulses got %0d exp 1", pulses); end
        n_vec++; if (pc !== 8'h10) begin n_err++; $display("FAIL bp_step_pc got %h exp 10", pc); end
    endtask

    // DIVISOR=1: a mode change on a tick cycle swallows that pulse.
    task automatic test_mode_change_on_tick();
        mode_sel = 2'b01; bp_en = 1'b0;
        do_reset();
        repeat (4) step_clk();
        n_vec++; if (ce1 !== 1'b1) begin n_err++; $display("FAIL mc_pre_ce got %b exp 1", ce1); end
        mode_sel = 2'b11;
        step_clk();
        n_vec++; if (ce1 !== 1'b0) begin n_err++; $display("FAIL mc_change_ce got %b exp 0", ce1); end
        step_clk();
        n_vec++; if (ce1 !== 1'b1) begin n_err++; $display("FAIL mc_after_ce got %b exp 1", ce1); end
    endtask

    // DIVISOR=4: reset after 3 pulses clears everything and restarts the divider.
    task automatic test_reset_mid_run();
        mode_sel = 2'b01;
        do_reset();
        for (int k = 0; k <= 12; k++) step_clk();
        n_vec++; if (cnt4 !== 32'd3) begin n_err++; $display("FAIL mid_cnt_pre got %0d exp 3", cnt4); end
        SYS_reset = 1'b1;
        step_clk();
        n_vec++; if (ce4 !== 1'b0)   begin n_err++; $display("FAIL mid_ce got %b exp 0", ce4); end
        n_vec++; if (led4 !== 1'b0)  begin n_err++; $display("FAIL mid_led got %b exp 0", led4); end
        n_vec++; if (hlt4 !== 1'b0)  begin n_err++; $display("FAIL mid_halted got %b exp 0", hlt4); end
        n_vec++; if (cnt4 !== 32'd0) begin n_err++; $display("FAIL mid_cnt got %0d exp 0", cnt4); end
        SYS_reset = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            step_clk();
            n_vec++;
            if (ce4 !== (k == 4)) begin n_err++; $display("FAIL mid_restart_ce edge %0d got %b exp %b", k, ce4, (k == 4)); end
        end
        n_vec++; if (cnt4 !== 32'd1) begin n_err++; $display("FAIL mid_restart_cnt got %0d exp 1", cnt4); end
    endtask

    // CYC_W=4, DIVISOR=1: count saturates at 15 while CLK_led keeps toggling.
    task automatic test_saturate();
        logic [3:0] exp_cnt;
        mode_sel = 2'b01;
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            step_clk();
            if (k >= 1) begin
                exp_cnt = (k > 15) ? 4'd15 : 4'(k);
                n_vec++;
                if (cnts !== exp_cnt) begin n_err++; $display("FAIL sat_cnt edge %0d got %0d exp %0d", k, cnts, exp_cnt); end
                n_vec++;
                if (leds !== k[0]) begin n_err++; $display("FAIL sat_led edge %0d got %b exp %b", k, leds, k[0]); end
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        SYS_reset = 1'b0; mode_sel = 2'b00; step_btn = 1'b0;
        bp_en = 1'b0; bp_addr = 8'h00; pc = 8'h00;
        test_reset();
        test_run_div4();
        test_run_halt_div1();
        test_step();
        test_run_to_bp();
        test_mode_change_on_tick();
        test_reset_mid_run();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
